// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator.
// Defaults describe the standard 640x480 @ 60 Hz mode.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    typedef enum logic {
        POL_ACTIVE_LOW  = 1'b0,
        POL_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // Four segment lengths always sum without overflow in two extra bits.
    localparam int TOT_EXTRA_BITS = 2;

endpackage

// File: rtl/vga_timing_generator_pixel_tick_sync.sv
// Two-flop synchroniser plus falling-edge one-shot for PixelClock.
// Flops reset high so a high PixelClock at release yields no tick.
module pixel_tick_sync (
    input  logic clock,
    input  logic reset,
    input  logic pixel_clock,
    output logic tick
);

    logic sync1_q, sync2_q, prev_q;
    logic sync1_d, sync2_d, prev_d;

    always_comb begin
        sync1_d = pixel_clock;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign tick = prev_q & ~sync2_q;

endmodule

// File: rtl/vga_timing_generator.sv
// Horizontal + vertical VGA timing generator with frame-boundary
// shadowed timing, per-axis sync polarity and a synchronised pixel tick.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int XRESOLUTION = 10,
    parameter int YRESOLUTION = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   PixelClock,
    input  logic [XRESOLUTION-1:0] HActive,
    input  logic [XRESOLUTION-1:0] HFront,
    input  logic [XRESOLUTION-1:0] HSync,
    input  logic [XRESOLUTION-1:0] HBack,
    input  logic [YRESOLUTION-1:0] VActive,
    input  logic [YRESOLUTION-1:0] VFront,
    input  logic [YRESOLUTION-1:0] VSync,
    input  logic [YRESOLUTION-1:0] VBack,
    input  logic                   HsyncPolarity,
    input  logic                   VsyncPolarity,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   VideoActive,
    output logic [XRESOLUTION-1:0] xposition,
    output logic [YRESOLUTION-1:0] yposition,
    output logic                   LineEnd,
    output logic                   FrameEnd
);

    localparam int XW = XRESOLUTION + TOT_EXTRA_BITS;
    localparam int YW = YRESOLUTION + TOT_EXTRA_BITS;
    localparam logic [XW-1:0] XMAX = XW'(2 ** XRESOLUTION);
    localparam logic [YW-1:0] YMAX = YW'(2 ** YRESOLUTION);

    logic tick;

    pixel_tick_sync u_tick (
        .clock       (clock),
        .reset       (reset),
        .pixel_clock (PixelClock),
        .tick        (tick)
    );

    logic [XRESOLUTION-1:0] h_act_q, h_fp_q, h_sw_q, h_bp_q;
    logic [XRESOLUTION-1:0] h_act_d, h_fp_d, h_sw_d, h_bp_d;
    logic [YRESOLUTION-1:0] v_act_q, v_fp_q, v_sw_q, v_bp_q;
    logic [YRESOLUTION-1:0] v_act_d, v_fp_d, v_sw_d, v_bp_d;
    logic                   hpol_q, vpol_q, hpol_d, vpol_d;
    logic                   load_pending_q, load_pending_d;

    logic [XRESOLUTION-1:0] x_q, x_d;
    logic [YRESOLUTION-1:0] y_q, y_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   va_q, va_d;

    logic [XW-1:0] h_raw, h_tot, h_last, h_beg_n, h_end_n;
    logic [YW-1:0] v_raw, v_tot, v_last, v_beg_n, v_end_n;
    logic          line_end, frame_end, load;
    logic          in_h, in_v;

    // Totals and end-of-line/frame decode from the current shadows.
    always_comb begin
        h_raw = XW'(h_act_q) + XW'(h_fp_q) + XW'(h_sw_q) + XW'(h_bp_q);
        v_raw = YW'(v_act_q) + YW'(v_fp_q) + YW'(v_sw_q) + YW'(v_bp_q);
        h_tot = (h_raw > XMAX) ? XMAX : h_raw;
        v_tot = (v_raw > YMAX) ? YMAX : v_raw;
        h_last = h_tot - XW'(1);
        v_last = v_tot - YW'(1);
        line_end  = (h_tot != '0) && (XW'(x_q) == h_last);
        frame_end = line_end && (v_tot != '0) && (YW'(y_q) == v_last);
        load = load_pending_q || (tick && frame_end)
            || (h_tot == '0) || (v_tot == '0);
    end

    always_comb begin
        h_act_d = load ? HActive : h_act_q;
        h_fp_d  = load ? HFront  : h_fp_q;
        h_sw_d  = load ? HSync   : h_sw_q;
        h_bp_d  = load ? HBack   : h_bp_q;
        v_act_d = load ? VActive : v_act_q;
        v_fp_d  = load ? VFront  : v_fp_q;
        v_sw_d  = load ? VSync   : v_sw_q;
        v_bp_d  = load ? VBack   : v_bp_q;
        hpol_d  = load ? HsyncPolarity : hpol_q;
        vpol_d  = load ? VsyncPolarity : vpol_q;
        load_pending_d = 1'b0;
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if ((h_tot == '0) || line_end) x_d = '0;
            else x_d = x_q + XRESOLUTION'(1);
        end
        if (tick && line_end) begin
            if ((v_tot == '0) || (YW'(y_q) == v_last)) y_d = '0;
            else y_d = y_q + YRESOLUTION'(1);
        end
    end

    // Sync and active are decoded from next-state counts and shadows
    // so they land on the same edge as the position they describe.
    always_comb begin
        h_beg_n = XW'(h_act_d) + XW'(h_fp_d);
        h_end_n = h_beg_n + XW'(h_sw_d);
        v_beg_n = YW'(v_act_d) + YW'(v_fp_d);
        v_end_n = v_beg_n + YW'(v_sw_d);
        in_h = (XW'(x_d) >= h_beg_n) && (XW'(x_d) < h_end_n);
        in_v = (YW'(y_d) >= v_beg_n) && (YW'(y_d) < v_end_n);
        hsync_d = in_h ? hpol_d : ~hpol_d;
        vsync_d = in_v ? vpol_d : ~vpol_d;
        va_d = (x_d < h_act_d) && (y_d < v_act_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_act_q <= '0;
            h_fp_q  <= '0;
            h_sw_q  <= '0;
            h_bp_q  <= '0;
            v_act_q <= '0;
            v_fp_q  <= '0;
            v_sw_q  <= '0;
            v_bp_q  <= '0;
            hpol_q  <= POL_ACTIVE_LOW;
            vpol_q  <= POL_ACTIVE_LOW;
            load_pending_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            va_q    <= 1'b0;
        end else begin
            h_act_q <= h_act_d;
            h_fp_q  <= h_fp_d;
            h_sw_q  <= h_sw_d;
            h_bp_q  <= h_bp_d;
            v_act_q <= v_act_d;
            v_fp_q  <= v_fp_d;
            v_sw_q  <= v_sw_d;
            v_bp_q  <= v_bp_d;
            hpol_q  <= hpol_d;
            vpol_q  <= vpol_d;
            load_pending_q <= load_pending_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            va_q    <= va_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign VideoActive = va_q;
    assign xposition   = x_q;
    assign yposition   = y_q;
    assign LineEnd     = line_end;
    assign FrameEnd    = frame_end;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed self-checking bench for vga_timing_generator.
// Long frames use a reduced 16x10 mode to keep runtime short.
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    localparam int XR = 10;
    localparam int YR = 10;
    localparam int OW = XR + YR + 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic PixelClock = 1'b1;
    logic [XR-1:0] HActive, HFront, HSync, HBack;
    logic [YR-1:0] VActive, VFront, VSync, VBack;
    logic HsyncPolarity, VsyncPolarity;
    logic hsync, vsync, VideoActive, LineEnd, FrameEnd;
    logic [XR-1:0] xposition;
    logic [YR-1:0] yposition;

    int n_tests = 0;
    int n_fail = 0;
    int tick_cnt = 0;

    int sh_ha, sh_hf, sh_hs, sh_hb, sh_va, sh_vf, sh_vs, sh_vb;
    logic sh_hp, sh_vp;
    int mx, my;

    vga_timing_generator #(.XRESOLUTION(XR), .YRESOLUTION(YR)) u_dut (
        .clock(clock), .reset(reset), .PixelClock(PixelClock),
        .HActive(HActive), .HFront(HFront), .HSync(HSync), .HBack(HBack),
        .VActive(VActive), .VFront(VFront), .VSync(VSync), .VBack(VBack),
        .HsyncPolarity(HsyncPolarity), .VsyncPolarity(VsyncPolarity),
        .hsync(hsync), .vsync(vsync), .VideoActive(VideoActive),
        .xposition(xposition), .yposition(yposition),
        .LineEnd(LineEnd), .FrameEnd(FrameEnd)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (u_dut.tick === 1'b1) tick_cnt++;

    function automatic void m_load();
        sh_ha = HActive; sh_hf = HFront; sh_hs = HSync; sh_hb = HBack;
        sh_va = VActive; sh_vf = VFront; sh_vs = VSync; sh_vb = VBack;
        sh_hp = HsyncPolarity; sh_vp = VsyncPolarity;
    endfunction

    function automatic int m_htot();
        return sh_ha + sh_hf + sh_hs + sh_hb;
    endfunction

    function automatic int m_vtot();
        return sh_va + sh_vf + sh_vs + sh_vb;
    endfunction

    function automatic void m_tick();
        int ht = m_htot();
        int vt = m_vtot();
        bit le = (ht != 0) && (mx == ht - 1);
        bit fe = le && (vt != 0) && (my == vt - 1);
        if (ht == 0 || le) mx = 0;
        else mx++;
        if (le) begin
            if (vt == 0 || my == vt - 1) my = 0;
            else my++;
        end
        if (fe || ht == 0 || vt == 0) m_load();
    endfunction

    function automatic logic [OW-1:0] expv();
        int ht = m_htot();
        int vt = m_vtot();
        logic le, fe, hs, vs, va;
        le = (ht != 0) && (mx == ht - 1);
        fe = le && (vt != 0) && (my == vt - 1);
        hs = (mx >= sh_ha + sh_hf && mx < sh_ha + sh_hf + sh_hs) ? sh_hp : !sh_hp;
        vs = (my >= sh_va + sh_vf && my < sh_va + sh_vf + sh_vs) ? sh_vp : !sh_vp;
        va = (mx < sh_ha) && (my < sh_va);
        return {XR'(mx), YR'(my), hs, vs, va, le, fe};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {xposition, yposition, hsync, vsync, VideoActive, LineEnd, FrameEnd};
    endfunction

    function automatic string st(logic [OW-1:0] v);
        return $sformatf("x=%0d y=%0d hs=%b vs=%b va=%b le=%b fe=%b",
            v[OW-1 -: XR], v[YR+4:5], v[4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic pix_tick();
        PixelClock = 1'b0;
        repeat (2) @(negedge clock);
        PixelClock = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic set_vga();
        HActive = H_ACTIVE_DEF; HFront = H_FRONT_DEF;
        HSync = H_SYNC_DEF; HBack = H_BACK_DEF;
        VActive = V_ACTIVE_DEF; VFront = V_FRONT_DEF;
        VSync = V_SYNC_DEF; VBack = V_BACK_DEF;
        HsyncPolarity = POL_ACTIVE_LOW; VsyncPolarity = POL_ACTIVE_LOW;
    endtask

    task automatic set_small();
        HActive = 8; HFront = 2; HSync = 3; HBack = 3;
        VActive = 6; VFront = 1; VSync = 2; VBack = 1;
        HsyncPolarity = POL_ACTIVE_LOW; VsyncPolarity = POL_ACTIVE_LOW;
    endtask

    task automatic do_reset();
        PixelClock = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        mx = 0; my = 0;
        m_load();
        @(negedge clock);
    endtask

    task automatic test_reset();
        set_vga();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if (obs() !== {XR'(0), YR'(0), 5'b11000}) begin
            n_fail++;
            $display("FAIL reset_values got %s want x=0 y=0 hs=1 vs=1 va=0 le=0 fe=0",
                st(obs()));
        end
        reset = 1'b1;
        mx = 0; my = 0;
        m_load();
        repeat (4) @(negedge clock);
        n_tests++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_release got %s want %s", st(obs()), st(expv()));
        end
    endtask

    task automatic test_std_mode();
        int hs_low = 0;
        int le_cnt = 0;
        set_vga();
        do_reset();
        for (int i = 1; i <= 1600; i++) begin
            pix_tick();
            m_tick();
            if (i <= 800 && hsync === 1'b0) hs_low++;
            if (LineEnd === 1'b1) le_cnt++;
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL std_mode tick %0d got %s want %s", i, st(obs()), st(expv()));
            end
        end
        n_tests++;
        if (hs_low != 96) begin
            n_fail++;
            $display("FAIL std_hsync_width got %0d want 96", hs_low);
        end
        n_tests++;
        if (le_cnt != 2) begin
            n_fail++;
            $display("FAIL std_line_end_count got %0d want 2", le_cnt);
        end
        n_tests++;
        if (yposition !== YR'(2)) begin
            n_fail++;
            $display("FAIL std_line_count got %0d want 2", yposition);
        end
    endtask

    task automatic test_small_frame();
        int fe_cnt = 0;
        int vs_low = 0;
        set_small();
        do_reset();
        for (int i = 1; i <= 320; i++) begin
            if (FrameEnd === 1'b1) fe_cnt++;
            pix_tick();
            m_tick();
            if (i <= 160 && vsync === 1'b0) vs_low++;
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL small_frame tick %0d got %s want %s", i, st(obs()), st(expv()));
            end
        end
        n_tests++;
        if (fe_cnt != 2) begin
            n_fail++;
            $display("FAIL frame_end_count got %0d want 2", fe_cnt);
        end
        n_tests++;
        if (vs_low != 32) begin
            n_fail++;
            $display("FAIL vsync_width got %0d want 32", vs_low);
        end
    endtask

    task automatic test_polarity();
        set_small();
        do_reset();
        for (int i = 1; i <= 320; i++) begin
            if (i == 51) begin
                HsyncPolarity = POL_ACTIVE_HIGH;
                VsyncPolarity = POL_ACTIVE_HIGH;
            end
            pix_tick();
            m_tick();
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL polarity tick %0d got %s want %s", i, st(obs()), st(expv()));
            end
        end
    endtask

    task automatic test_mid_frame_change();
        set_small();
        do_reset();
        for (int i = 1; i <= 280; i++) begin
            if (i == 51) HActive = 4;
            pix_tick();
            m_tick();
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL mid_frame tick %0d got %s want %s", i, st(obs()), st(expv()));
            end
        end
    endtask

    task automatic test_zero_timing();
        HActive = 0; HFront = 0; HSync = 0; HBack = 0;
        VActive = 0; VFront = 0; VSync = 0; VBack = 0;
        HsyncPolarity = POL_ACTIVE_LOW; VsyncPolarity = POL_ACTIVE_LOW;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            pix_tick();
            m_tick();
            n_tests++;
            if (obs() !== {XR'(0), YR'(0), 5'b11000}) begin
                n_fail++;
                $display("FAIL zero_hold tick %0d got %s want x=0 y=0 hs=1 vs=1 va=0", i, st(obs()));
            end
        end
        set_vga();
        m_load();
        @(negedge clock);
        n_tests++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL zero_to_vga_load got %s want %s", st(obs()), st(expv()));
        end
        pix_tick();
        m_tick();
        n_tests++;
        if (xposition !== XR'(1) || obs() !== expv()) begin
            n_fail++;
            $display("FAIL zero_to_vga_count got %s want %s", st(obs()), st(expv()));
        end
    endtask

    task automatic test_reset_mid_line();
        set_small();
        do_reset();
        for (int i = 1; i <= 69; i++) begin
            pix_tick();
            m_tick();
        end
        n_tests++;
        if (xposition !== XR'(5) || yposition !== YR'(4)) begin
            n_fail++;
            $display("FAIL pre_reset_pos got x=%0d y=%0d want x=5 y=4", xposition, yposition);
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (obs() !== {XR'(0), YR'(0), 5'b11000}) begin
            n_fail++;
            $display("FAIL async_reset got %s want x=0 y=0 hs=1 vs=1 va=0 le=0 fe=0", st(obs()));
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        mx = 0; my = 0;
        m_load();
        repeat (6) @(negedge clock);
        n_tests++;
        if (xposition !== XR'(0)) begin
            n_fail++;
            $display("FAIL no_tick_after_release got x=%0d want 0", xposition);
        end
        pix_tick();
        m_tick();
        n_tests++;
        if (xposition !== XR'(1) || obs() !== expv()) begin
            n_fail++;
            $display("FAIL first_tick_after_reset got %s want %s", st(obs()), st(expv()));
        end
    endtask

    task automatic test_sync_stress();
        set_vga();
        do_reset();
        tick_cnt = 0;
        for (int i = 1; i <= 1000; i++) begin
            pix_tick();
            m_tick();
        end
        n_tests++;
        if (tick_cnt != 1000) begin
            n_fail++;
            $display("FAIL sync_tick_count got %0d want 1000", tick_cnt);
        end
        n_tests++;
        if (xposition !== XR'(200) || yposition !== YR'(1) || obs() !== expv()) begin
            n_fail++;
            $display("FAIL sync_final_pos got %s want %s", st(obs()), st(expv()));
        end
    endtask

    initial begin
        test_reset();
        test_std_mode();
        test_small_frame();
        test_polarity();
        test_mid_frame_change();
        test_zero_timing();
        test_reset_mid_line();
        test_sync_stress();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
